period_countdown: RTL and testbench

Parametrised countdown period controller for the game flow. It generalises the fixed preliminary-period timer. The duration is derived from the current level with clamping. The digit count is configurable. It adds pause and abort controls, a restart-on-start behaviour, a BCD remaining-time output and a one-cycle done pulse. It sits between the game-flow sequencer and the seven-segment display mux, and runs in the Clk100M domain with a slow Clk1Hz input.

---
 rtl/period_countdown.sv | 186 ++++++++++++++++++
 tb/tb_period_countdown.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/period_countdown.sv
// Level-driven countdown period controller: loads a clamped duration, converts it to BCD,
// counts down on synchronised 1 Hz ticks and drives a multiplexed seven-segment display.
module period_countdown #(
    parameter int NUM_DIGITS = 2,
    parameter int LEVEL_W    = 4,
    parameter int BASE_SECS  = 30,
    parameter int STEP_SECS  = 2,
    parameter int MIN_SECS   = 5
) (
    input  logic                    Clk100M,
    input  logic                    Rst_n,
    input  logic                    Clk1Hz,
    input  logic                    startSig,
    input  logic                    abortSig,
    input  logic                    pauseSig,
    input  logic [LEVEL_W-1:0]      curLevel,
    output logic                    doneSig,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] remaining,
    output logic [8*NUM_DIGITS-1:0] segOut
);

    localparam int CNT_W    = 4 * NUM_DIGITS;
    localparam int MAX_SECS = (NUM_DIGITS == 1) ? 9 :
                              (NUM_DIGITS == 2) ? 99 :
                              (NUM_DIGITS == 3) ? 999 : 9999;
    localparam int BIT_W    = $clog2(CNT_W + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] PAUSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state;
    logic [BIT_W-1:0] bitCnt;
    logic [CNT_W-1:0] binShift;
    logic [CNT_W-1:0] bcdAcc;
    logic [CNT_W-1:0] bcdNext;
    logic [CNT_W-1:0] durSat;
    logic signed [31:0] lvlS;
    logic signed [31:0] durRaw;
    logic hzSync_p0, hzSync_p1, hzSync_p2, tick;
    logic startQ, startEdge, loadNow;

    function automatic logic [CNT_W-1:0] satDur(input logic signed [31:0] raw);
        if (raw < MIN_SECS)
            satDur = CNT_W'(MIN_SECS);
        else if (raw > MAX_SECS)
            satDur = CNT_W'(MAX_SECS);
        else
            satDur = CNT_W'(raw);
    endfunction

    // One double-dabble step: correct each digit >= 5, then shift the next binary bit in.
    function automatic logic [CNT_W-1:0] addShift(input logic [CNT_W-1:0] acc, input logic inBit);
        logic [CNT_W-1:0] t;
        t = acc;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (t[4*d +: 4] >= 4'd5)
                t[4*d +: 4] = t[4*d +: 4] + 4'd3;
        addShift = {t[CNT_W-2:0], inBit};
    endfunction

    function automatic logic [CNT_W-1:0] bcdDec(input logic [CNT_W-1:0] v);
        logic borrow;
        bcdDec = v;
        borrow = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (borrow) begin
                if (v[4*d +: 4] == 4'd0) begin
                    bcdDec[4*d +: 4] = 4'd9;
                end else begin
                    bcdDec[4*d +: 4] = v[4*d +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic [6:0] segDecode(input logic [3:0] v);
        case (v)
            4'd0:    segDecode = 7'h40;
            4'd1:    segDecode = 7'h79;
            4'd2:    segDecode = 7'h24;
            4'd3:    segDecode = 7'h30;
            4'd4:    segDecode = 7'h19;
            4'd5:    segDecode = 7'h12;
            4'd6:    segDecode = 7'h02;
            4'd7:    segDecode = 7'h78;
            4'd8:    segDecode = 7'h00;
            4'd9:    segDecode = 7'h10;
            default: segDecode = 7'h7F;
        endcase
    endfunction

    assign lvlS      = signed'(32'(curLevel));
    assign durRaw    = BASE_SECS - lvlS * STEP_SECS;
    assign durSat    = satDur(durRaw);
    assign startEdge = startSig & ~startQ;
    assign loadNow   = startEdge & ~abortSig;
    assign bcdNext   = addShift(bcdAcc, binShift[CNT_W-1]);

    // Stage boundary: Clk1Hz crosses into Clk100M, tick emerges three edges after the rise.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            hzSync_p0 <= 1'b0;
            hzSync_p1 <= 1'b0;
            hzSync_p2 <= 1'b0;
            tick      <= 1'b0;
            startQ    <= 1'b0;
        end else begin
            hzSync_p0 <= Clk1Hz;
            hzSync_p1 <= hzSync_p0;
            hzSync_p2 <= hzSync_p1;
            tick      <= hzSync_p1 & ~hzSync_p2;
            startQ    <= startSig;
        end
    end

    // Stage boundary: binary-to-BCD shift datapath, seeded on every accepted start edge.
    always_ff @(posedge Clk100M) begin
        if (loadNow) begin
            binShift <= durSat;
            bcdAcc   <= '0;
        end else if (state == LOAD) begin
            binShift <= binShift << 1;
            bcdAcc   <= bcdNext;
        end
    end

    // Stage boundary: control FSM; abort outranks start, start outranks pause, pause outranks tick.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            bitCnt    <= '0;
            remaining <= '0;
            doneSig   <= 1'b0;
        end else begin
            doneSig <= 1'b0;
            if (abortSig) begin
                state     <= IDLE;
                remaining <= '0;
            end else if (startEdge) begin
                state  <= LOAD;
                bitCnt <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: begin
                        if (bitCnt == BIT_W'(CNT_W - 1)) begin
                            state     <= RUN;
                            remaining <= bcdNext;
                        end else begin
                            bitCnt <= bitCnt + BIT_W'(1);
                        end
                    end
                    RUN: begin
                        if (pauseSig) begin
                            state <= PAUSE;
                        end else if (tick) begin
                            remaining <= bcdDec(remaining);
                            if (remaining == CNT_W'(1)) begin
                                state   <= DONE;
                                doneSig <= 1'b1;
                            end
                        end
                    end
                    PAUSE: if (!pauseSig) state <= RUN;
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == LOAD) || (state == RUN) || (state == PAUSE);

    always_comb begin
        segOut = '1;
        if (state != IDLE)
            for (int d = 0; d < NUM_DIGITS; d++)
                segOut[8*d +: 8] = {state != PAUSE, segDecode(remaining[4*d +: 4])};
    end

endmodule

// File: tb/tb_period_countdown.sv
// Directed bench for period_countdown with a cycle-level behavioural model of the period flow.
module tb_period_countdown;

    logic        clk = 1'b0;
    logic        Rst_n, Clk1Hz, startSig, abortSig, pauseSig, start1;
    logic [3:0]  curLevel, lvl1;
    logic        doneSig, busy, done1, busy1;
    logic [7:0]  remaining;
    logic [15:0] segOut;
    logic [3:0]  rem1;
    logic [7:0]  seg1;

    int tests = 0;
    int fails = 0;
    int donePulses = 0;

    period_countdown dut (
        .Clk100M(clk), .Rst_n(Rst_n), .Clk1Hz(Clk1Hz), .startSig(startSig),
        .abortSig(abortSig), .pauseSig(pauseSig), .curLevel(curLevel),
        .doneSig(doneSig), .busy(busy), .remaining(remaining), .segOut(segOut)
    );

    period_countdown #(.NUM_DIGITS(1)) dut1 (
        .Clk100M(clk), .Rst_n(Rst_n), .Clk1Hz(Clk1Hz), .startSig(start1),
        .abortSig(abortSig), .pauseSig(pauseSig), .curLevel(lvl1),
        .doneSig(done1), .busy(busy1), .remaining(rem1), .segOut(seg1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: seconds as an integer, modes 0 idle, 1 load, 2 run, 3 pause, 4 done.
    int   mMode, mSecs, mLoadLeft, mPend;
    bit   mPrevStart, mDone;
    bit   hzHist [0:3];
    logic [7:0] segTab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic int durOf(input int lvl);
        int d;
        d = 30 - lvl * 2;
        if (d < 5) d = 5;
        if (d > 99) d = 99;
        return d;
    endfunction

    function automatic logic [7:0] expRem(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] expSeg(input int mode, input int s);
        logic [7:0] hi, lo;
        if (mode == 0) return 16'hFFFF;
        hi = segTab[s / 10];
        lo = segTab[s % 10];
        if (mode == 3) begin
            hi = hi & 8'h7F;
            lo = lo & 8'h7F;
        end
        return {hi, lo};
    endfunction

    always @(posedge clk) begin
        bit tk, se;
        if (!Rst_n) begin
            mMode = 0; mSecs = 0; mLoadLeft = 0; mPend = 0;
            mPrevStart = 0; mDone = 0;
            for (int i = 0; i < 4; i++) hzHist[i] = 0;
        end else begin
            tk = hzHist[2] && !hzHist[3];
            se = startSig && !mPrevStart;
            mPrevStart = startSig;
            mDone = 0;
            if (abortSig) begin
                mMode = 0; mSecs = 0;
            end else if (se) begin
                mMode = 1; mLoadLeft = 8; mPend = durOf(int'(curLevel));
            end else if (mMode == 1) begin
                mLoadLeft--;
                if (mLoadLeft == 0) begin
                    mMode = 2; mSecs = mPend;
                end
            end else if (mMode == 2) begin
                if (pauseSig) mMode = 3;
                else if (tk) begin
                    mSecs--;
                    if (mSecs == 0) begin
                        mMode = 4; mDone = 1;
                    end
                end
            end else if (mMode == 3) begin
                if (!pauseSig) mMode = 2;
            end
            for (int i = 3; i > 0; i--) hzHist[i] = hzHist[i-1];
            hzHist[0] = Clk1Hz;
        end
    end

    always @(posedge clk) begin
        #1;
        if (doneSig) donePulses++;
        chk("model busy", 32'(busy), 32'(mMode >= 1 && mMode <= 3));
        chk("model done", 32'(doneSig), 32'(mDone));
        chk("model remaining", 32'(remaining), 32'(expRem(mSecs)));
        chk("model segOut", 32'(segOut), 32'(expSeg(mMode, mSecs)));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doTick();
        Clk1Hz = 1'b1;
        cyc(4);
        Clk1Hz = 1'b0;
        cyc(4);
    endtask

    initial begin
        Rst_n = 0; Clk1Hz = 0; startSig = 0; abortSig = 0; pauseSig = 0;
        start1 = 0; curLevel = 0; lvl1 = 0;
        cyc(3);
        Rst_n = 1;
        cyc(20);
        chk("reset segOut", 32'(segOut), 32'h0000FFFF);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset remaining", 32'(remaining), 32'd0);
        chk("reset no done", 32'(donePulses), 32'd0);

        curLevel = 4'd3; startSig = 1;
        cyc(1);
        chk("start busy", 32'(busy), 32'd1);
        cyc(11);
        chk("level3 load", 32'(remaining), 32'h24);
        repeat (24) doTick();
        chk("countdown done pulses", 32'(donePulses), 32'd1);
        chk("done remaining", 32'(remaining), 32'h00);
        chk("done segOut", 32'(segOut), 32'h0000C0C0);
        cyc(20);
        chk("done holds", 32'(segOut), 32'h0000C0C0);

        startSig = 0; cyc(2);
        curLevel = 4'd15; startSig = 1; start1 = 1;
        cyc(12);
        chk("level15 clamp", 32'(remaining), 32'h05);
        chk("1digit clamp", 32'(rem1), 32'h9);
        chk("1digit seg", 32'(seg1), 32'h90);

        startSig = 0; cyc(2);
        curLevel = 4'd0; startSig = 1;
        cyc(12);
        chk("level0 load", 32'(remaining), 32'h30);
        repeat (20) doTick();
        chk("run at 10", 32'(remaining), 32'h10);
        pauseSig = 1;
        repeat (3) doTick();
        chk("pause held", 32'(remaining), 32'h10);
        chk("pause dp", 32'(segOut), 32'h00007940);
        pauseSig = 0;
        doTick();
        chk("borrow 09", 32'(remaining), 32'h09);

        repeat (7) doTick();
        chk("run at 02", 32'(remaining), 32'h02);
        Clk1Hz = 1; cyc(3);
        abortSig = 1; cyc(1);
        chk("abort remaining", 32'(remaining), 32'd0);
        chk("abort segOut", 32'(segOut), 32'h0000FFFF);
        chk("abort busy", 32'(busy), 32'd0);
        Clk1Hz = 0; cyc(4);
        abortSig = 0; cyc(2);
        chk("abort no done", 32'(donePulses), 32'd1);

        startSig = 0; cyc(2);
        startSig = 1; cyc(12);
        repeat (15) doTick();
        chk("run at 15", 32'(remaining), 32'h15);
        startSig = 0; cyc(2);
        startSig = 1; cyc(12);
        chk("restart reload", 32'(remaining), 32'h30);
        chk("restart no done", 32'(donePulses), 32'd1);
        startSig = 0; cyc(2);
        abortSig = 1; startSig = 1; cyc(1);
        chk("start+abort idle", 32'(busy), 32'd0);
        chk("start+abort blank", 32'(segOut), 32'h0000FFFF);
        abortSig = 0; cyc(2);
        chk("stays idle", 32'(busy), 32'd0);

        startSig = 0; cyc(2);
        startSig = 1; cyc(12);
        repeat (3) doTick();
        Rst_n = 0; #1;
        chk("midreset blank", 32'(segOut), 32'h0000FFFF);
        chk("midreset busy", 32'(busy), 32'd0);
        cyc(2);
        Rst_n = 1; startSig = 0;
        cyc(5);
        chk("midreset no done", 32'(donePulses), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
